// File: rtl/regfile_mp.sv
// regfile_mp: multi-read register file with two bypassed write ports, pending scoreboard and sequential clear
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h000007fc
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_INDEX);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [ADDR_W-1:0] clrIdx;
  logic wr0, wr1, mark;
  // Traffic is dropped while clearing; register 0 is never a target
  assign wr0 = we0 && !clr_busy && (waddr0 != '0);
  assign wr1 = we1 && !clr_busy && (waddr1 != '0);
  assign mark = mark_en && !clr_busy && (mark_addr != '0);
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] a;
    logic hit;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = (wr0 && (waddr0 == a)) || (wr1 && (waddr1 == a));
    assign rd_data[k*DATA_W +: DATA_W] = (a == '0) ? '0 :
                                         (wr1 && (waddr1 == a)) ? wdata1 :
                                         (wr0 && (waddr0 == a)) ? wdata0 : regs[a];
    assign rd_pending[k] = pend[a] && !(hit && !(mark && (mark_addr == a)));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      pend <= '0;
      state <= IDLE;
      clrIdx <= '0;
      clr_busy <= 1'b0;
    end else if (state == CLEAR) begin
      regs[clrIdx] <= (clrIdx == SP_ADDR) ? SP_RESET : '0;
      pend[clrIdx] <= 1'b0;
      clrIdx <= clrIdx + ADDR_W'(1);
      if (clrIdx == '1) begin
        state <= IDLE;
        clr_busy <= 1'b0;
      end
    end else begin
      if (wr0) begin
        regs[waddr0] <= wdata0;
        pend[waddr0] <= 1'b0;
      end
      if (wr1) begin
        regs[waddr1] <= wdata1;
        pend[waddr1] <= 1'b0;
      end
      if (mark) pend[mark_addr] <= 1'b1;
      if (clr_req) begin
        state <= CLEAR;
        clrIdx <= ADDR_W'(1);
        clr_busy <= 1'b1;
      end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based reference model
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, D = 32;
  logic clk = 1'b0, reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_pending;
  logic we0, we1, mark_en, clr_req, clr_busy;
  logic [AW-1:0] waddr0, waddr1, mark_addr, dbg_addr;
  logic [DW-1:0] wdata0, wdata1, dbg_data;
  int nChk = 0, nPass = 0;
  logic [DW-1:0] mReg [D];
  bit mPend [D];
  int busyLeft;
  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .mark_en(mark_en), .mark_addr(mark_addr), .clr_req(clr_req), .clr_busy(clr_busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [DW-1:0] resetVal(int i);
    return (i == 29) ? 32'h7fc : 32'h0;
  endfunction
  task automatic modelReset;
    for (int i = 0; i < D; i++) begin
      mReg[i] = resetVal(i);
      mPend[i] = 1'b0;
    end
    busyLeft = 0;
  endtask
  function automatic logic [DW-1:0] expRd(logic [AW-1:0] a);
    if (a == 0) return 0;
    if (busyLeft == 0 && we1 && waddr1 == a) return wdata1;
    if (busyLeft == 0 && we0 && waddr0 == a) return wdata0;
    return mReg[a];
  endfunction
  function automatic bit expPend(logic [AW-1:0] a);
    bit wr = busyLeft == 0 && ((we0 && waddr0 == a) || (we1 && waddr1 == a));
    bit mk = busyLeft == 0 && mark_en && mark_addr == a;
    return a != 0 && mPend[a] && !(wr && !mk);
  endfunction
  task automatic compare;
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      a = rd_addr[k*AW +: AW];
      chk($sformatf("rd_data[%0d] addr %0d", k, a), 64'(rd_data[k*DW +: DW]), 64'(expRd(a)));
      chk($sformatf("rd_pending[%0d] addr %0d", k, a), 64'(rd_pending[k]), 64'(expPend(a)));
    end
    chk("clr_busy", 64'(clr_busy), 64'(busyLeft > 0));
    chk($sformatf("dbg_data addr %0d", dbg_addr), 64'(dbg_data), 64'((dbg_addr == 0) ? 32'h0 : mReg[dbg_addr]));
  endtask
  task automatic update;
    if (busyLeft > 0) begin
      mReg[D - busyLeft] = resetVal(D - busyLeft);
      mPend[D - busyLeft] = 1'b0;
      busyLeft--;
    end else begin
      if (we0 && waddr0 != 0) begin mReg[waddr0] = wdata0; mPend[waddr0] = 1'b0; end
      if (we1 && waddr1 != 0) begin mReg[waddr1] = wdata1; mPend[waddr1] = 1'b0; end
      if (mark_en && mark_addr != 0) mPend[mark_addr] = 1'b1;
      if (clr_req) busyLeft = D - 1;
    end
  endtask
  task automatic settle;
    #1;
    compare();
  endtask
  task automatic tick;
    @(posedge clk);
    update();
    @(negedge clk);
  endtask
  task automatic idleIn;
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    mark_en = 0; mark_addr = 0; clr_req = 0; rd_addr = 0; dbg_addr = 0;
  endtask
  task automatic dbgSweep(string tag);
    for (int i = 0; i < D; i++) begin
      dbg_addr = AW'(i);
      rd_addr = {AW'(i), AW'(i)};
      #1;
      chk($sformatf("%s dbg addr %0d", tag, i), 64'(dbg_data), 64'(resetVal(i)));
      chk($sformatf("%s pending addr %0d", tag, i), 64'(rd_pending), 64'(0));
    end
    @(negedge clk);
  endtask
  function automatic logic [AW-1:0] pickAddr;
    int r = int'($urandom_range(0, 9));
    return (r < 8) ? AW'(r) : (r == 8) ? AW'(29) : AW'($urandom_range(0, 31));
  endfunction
  task automatic randSteps(int n);
    for (int i = 0; i < n; i++) begin
      we0 = 1'($urandom_range(0, 1)); waddr0 = pickAddr(); wdata0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); waddr1 = pickAddr(); wdata1 = $urandom;
      mark_en = ($urandom_range(0, 2) == 0); mark_addr = pickAddr();
      clr_req = ($urandom_range(0, 60) == 0);
      rd_addr = {pickAddr(), pickAddr()};
      dbg_addr = pickAddr();
      settle();
      tick();
    end
    idleIn();
  endtask
  initial begin
    int busyCyc;
    idleIn();
    reset = 0;
    modelReset();
    @(negedge clk);
    dbgSweep("reset");
    chk("reset clr_busy", 64'(clr_busy), 64'(0));
    reset = 1;
    settle();
    tick();
    we0 = 1; waddr0 = 5; wdata0 = 32'haaaa; we1 = 1; waddr1 = 5; wdata1 = 32'h5555; rd_addr = 10'(5);
    settle();
    chk("dual write bypass", 64'(rd_data[DW-1:0]), 64'h5555);
    tick();
    idleIn(); dbg_addr = 5;
    settle();
    chk("dual write stored", 64'(dbg_data), 64'h5555);
    tick();
    mark_en = 1; mark_addr = 7; rd_addr = 10'(7);
    settle();
    tick();
    idleIn(); rd_addr = 10'(7);
    settle();
    chk("pending after mark", 64'(rd_pending[0]), 64'(1));
    tick();
    we0 = 1; waddr0 = 7; wdata0 = 32'h12; rd_addr = 10'(7);
    settle();
    chk("pending forced low", 64'(rd_pending[0]), 64'(0));
    chk("bypass w0", 64'(rd_data[DW-1:0]), 64'h12);
    tick();
    idleIn(); rd_addr = 10'(7);
    settle();
    chk("pending cleared", 64'(rd_pending[0]), 64'(0));
    tick();
    we0 = 1; waddr0 = 7; wdata0 = 32'h34; mark_en = 1; mark_addr = 7; rd_addr = 10'(7);
    settle();
    tick();
    idleIn(); rd_addr = 10'(7);
    settle();
    chk("mark+write keeps pending", 64'(rd_pending[0]), 64'(1));
    tick();
    we0 = 1; waddr0 = 0; wdata0 = 32'hffff; mark_en = 1; mark_addr = 0; rd_addr = 10'(0);
    settle();
    chk("reg0 bypass", 64'(rd_data[DW-1:0]), 64'(0));
    tick();
    idleIn();
    settle();
    chk("reg0 read", 64'(rd_data[DW-1:0]), 64'(0));
    chk("reg0 pending", 64'(rd_pending[0]), 64'(0));
    chk("reg0 dbg", 64'(dbg_data), 64'(0));
    tick();
    randSteps(600);
    while (busyLeft > 0) begin settle(); tick(); end
    for (int i = 1; i < D; i++) begin
      we0 = 1; waddr0 = AW'(i); wdata0 = $urandom | 32'h1; mark_en = 1; mark_addr = AW'(D - i);
      settle();
      tick();
    end
    idleIn(); clr_req = 1;
    settle();
    tick();
    busyCyc = 0;
    for (int c = 0; c < 100; c++) begin
      we0 = 1; waddr0 = 3; wdata0 = 32'hdead; mark_en = 1; mark_addr = 4; clr_req = 1;
      settle();
      if (!clr_busy) break;
      busyCyc++;
      tick();
    end
    idleIn();
    chk("clear busy length", 64'(busyCyc), 64'(31));
    dbgSweep("after clear");
    for (int i = 1; i < D; i++) begin
      we1 = 1; waddr1 = AW'(i); wdata1 = 32'(i * 3 + 1);
      settle();
      tick();
    end
    idleIn(); clr_req = 1;
    settle();
    tick();
    idleIn();
    repeat (10) begin settle(); tick(); end
    #2;
    reset = 0;
    #1;
    chk("abort clr_busy", 64'(clr_busy), 64'(0));
    modelReset();
    dbgSweep("after abort");
    reset = 1;
    settle();
    tick();
    randSteps(300);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
